// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and field widths for the L1 data cache
//                miss-handling controller (2-way, 16-set, 32-byte lines).
//                Address split: tag = addr[31:9], index = addr[8:5],
//                word = addr[4:2]. Tag entry: [24] valid, [23] dirty,
//                [22:0] tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int ADDR_W  = 32;
    localparam int TAG_W   = 23;
    localparam int IDX_W   = 4;
    localparam int SEL_W   = 3;
    localparam int OFF_W   = 5;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 256;
    localparam int ENTRY_W = 25;

    // Bit positions inside a tag entry
    localparam int VALID = 24;
    localparam int DIRTY = 23;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_line_merge.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_merge
//  Description : Combinational word merge. Returns line_i with the 32-bit
//                word selected by sel_i replaced by word_i.
//  Ports       : line_i [255:0] source line
//                word_i [31:0]  replacement word
//                sel_i  [2:0]   word position within the line
//                line_o [255:0] merged line
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [LINE_W-1:0] line_o
);

    localparam int WORDS = LINE_W / WORD_W;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_o[gi*WORD_W +: WORD_W] =
            (sel_i == SEL_W'(gi)) ? word_i : line_i[gi*WORD_W +: WORD_W];
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Miss-handling controller for the 2-way write-back L1 data
//                cache. Serves hits combinationally through the SRAM, stalls
//                the CPU on a miss, writes back a dirty victim, refills the
//                line from memory and installs it (merging store data).
//  Ports       : clk_i, rst_i            clock, async active-high reset
//                cpu_*                   CPU load/store port
//                sram_*                  tag/data SRAM (hit/victim lookup)
//                mem_*                   off-chip line memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    // CPU port
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_data_i,
    output logic [WORD_W-1:0]   cpu_data_o,
    output logic                cpu_stall_o,
    // SRAM port
    output logic                sram_enable_o,
    output logic                sram_write_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [ENTRY_W-1:0]  sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    input  logic                sram_hit_i,
    input  logic [ENTRY_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    // Memory port
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);

    state_t             r_state;
    state_t             w_next;

    // Miss context captured in IDLE; everything past IDLE works from these
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic [SEL_W-1:0]   r_sel;
    logic               r_we;
    logic [WORD_W-1:0]  r_wdata;
    logic [TAG_W-1:0]   r_victim_tag;
    logic [LINE_W-1:0]  r_victim_line;
    logic [LINE_W-1:0]  r_fill_line;

    logic [TAG_W-1:0]   w_cpu_tag;
    logic [IDX_W-1:0]   w_cpu_idx;
    logic [SEL_W-1:0]   w_cpu_sel;
    logic               w_idle;
    logic               w_update;
    logic               w_miss;
    logic               w_victim_dirty;
    logic [LINE_W-1:0]  w_merge_line;
    logic [WORD_W-1:0]  w_merge_word;
    logic [SEL_W-1:0]   w_merge_sel;
    logic [LINE_W-1:0]  w_merged;
    logic               w_unused;

    assign w_cpu_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_cpu_idx = cpu_addr_i[OFF_W +: IDX_W];
    assign w_cpu_sel = cpu_addr_i[2 +: SEL_W];
    assign w_unused  = ^cpu_addr_i[1:0];

    assign w_idle         = (r_state == IDLE);
    assign w_update       = (r_state == UPDATE);
    assign w_miss         = w_idle & cpu_req_i & ~sram_hit_i;
    assign w_victim_dirty = sram_tag_i[VALID] & sram_tag_i[DIRTY];

    assign cpu_data_o  = sram_data_i[w_cpu_sel*WORD_W +: WORD_W];
    assign cpu_stall_o = cpu_req_i & ~(w_idle & sram_hit_i);

    // A single merger serves both the store-hit path (live SRAM line and CPU
    // word) and the install path (refilled line and latched store word).
    assign w_merge_line = w_update ? r_fill_line : sram_data_i;
    assign w_merge_word = w_update ? r_wdata     : cpu_data_i;
    assign w_merge_sel  = w_update ? r_sel       : w_cpu_sel;

    dcache_line_merge u_merge (
        .line_i (w_merge_line),
        .word_i (w_merge_word),
        .sel_i  (w_merge_sel),
        .line_o (w_merged)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_tag         <= '0;
            r_idx         <= '0;
            r_sel         <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_victim_tag  <= '0;
            r_victim_line <= '0;
            r_fill_line   <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_tag         <= w_cpu_tag;
                r_idx         <= w_cpu_idx;
                r_sel         <= w_cpu_sel;
                r_we          <= cpu_we_i;
                r_wdata       <= cpu_data_i;
                r_victim_tag  <= sram_tag_i[TAG_W-1:0];
                r_victim_line <= sram_data_i;
            end
            if ((r_state == REFILL) && mem_ack_i) begin
                r_fill_line <= mem_data_i;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = w_cpu_idx;
        sram_tag_o    = {1'b1, cpu_we_i, w_cpu_tag};
        sram_data_o   = w_merged;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;

        case (r_state)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                // Store hit: tag {1, 1, tag} falls out of {1, cpu_we_i, tag}
                sram_write_o  = cpu_req_i & cpu_we_i & sram_hit_i;
                if (w_miss) begin
                    w_next = w_victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {r_victim_tag, r_idx, {OFF_W{1'b0}}};
                mem_data_o = r_victim_line;
                if (mem_ack_i) begin
                    w_next = REFILL;
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {r_tag, r_idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_next = UPDATE;
                end
            end
            UPDATE: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_addr_o   = r_idx;
                sram_tag_o    = {1'b1, r_we, r_tag};
                sram_data_o   = r_we ? w_merged : r_fill_line;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Scoreboard bench for dcache_ctrl with a 2-way LRU SRAM
//                model and a fixed-latency line memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int MEM_LAT = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cpu_req_i, cpu_we_i;
    logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
    logic          cpu_stall_o;
    logic          sram_enable_o, sram_write_o;
    logic [3:0]    sram_addr_o;
    logic [24:0]   sram_tag_o, sram_tag_i;
    logic [255:0]  sram_data_o, sram_data_i;
    logic          sram_hit_i;
    logic          mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]   mem_addr_o;
    logic [255:0]  mem_data_o, mem_data_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_hit_i(sram_hit_i), .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = a ^ 32'(32'h0101_0101 * (w + 1)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] l, input logic [31:0] d, input int s);
        logic [255:0] r;
        r = l;
        r[s*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [24:0] entry(input logic v, input logic d, input logic [22:0] t);
        return {v, d, t};
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic         we;
        logic         chk_data;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0]   idx;
        logic [24:0]  tag;
        logic [255:0] data;
    } sram_exp_t;

    mem_exp_t    mem_q[$];
    sram_exp_t   sram_q[$];
    logic [31:0] cpu_q[$];

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [255:0] data);
        mem_exp_t e;
        e.we = we; e.chk_data = we; e.addr = addr; e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic exp_sram(input logic [3:0] idx, input logic [24:0] tag, input logic [255:0] data);
        sram_exp_t e;
        e.idx = idx; e.tag = tag; e.data = data;
        sram_q.push_back(e);
    endtask

    // ---------------- SRAM model: 2 ways x 16 sets, LRU victim ----------------
    logic [24:0]  tag_mem  [2][16];
    logic [255:0] data_mem [2][16];
    logic         lru      [16];
    logic         sram_clr;
    logic         h0, h1, sel_way;

    always_comb begin
        h0 = tag_mem[0][sram_addr_o][24] && (tag_mem[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
        h1 = tag_mem[1][sram_addr_o][24] && (tag_mem[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
        sel_way     = h0 ? 1'b0 : (h1 ? 1'b1 : lru[sram_addr_o]);
        sram_hit_i  = sram_enable_o && (h0 || h1);
        sram_tag_i  = tag_mem[sel_way][sram_addr_o];
        sram_data_i = data_mem[sel_way][sram_addr_o];
    end

    always @(posedge clk_i) begin
        if (sram_clr) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 16; s++) begin
                    tag_mem[w][s]  <= '0;
                    data_mem[w][s] <= '0;
                end
            for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
        end else if (sram_enable_o) begin
            if (sram_write_o) begin
                tag_mem[sel_way][sram_addr_o]  <= sram_tag_o;
                data_mem[sel_way][sram_addr_o] <= sram_data_o;
            end
            if (sram_write_o || sram_hit_i) lru[sram_addr_o] <= ~sel_way;
        end
    end

    // ---------------- memory model: 0 auto, 1 hold, 2 ack every cycle ----------------
    int mem_mode = 0;

    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            if (mem_mode == 2) begin
                mem_ack_i = 1'b1;
            end else if (mem_mode == 0 && mem_req_o && !rst_i) begin
                if (cnt >= MEM_LAT - 1) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_we_o ? '0 : line_pat(mem_addr_o);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        mem_exp_t  me;
        sram_exp_t se;
        logic [31:0] ce;
        forever begin
            @(negedge clk_i);
            if (!rst_i && mem_req_o && mem_ack_i) begin
                if (mem_q.size() == 0) fail_now("mem_unexpected_transfer");
                else begin
                    me = mem_q.pop_front();
                    check("mem_we", mem_we_o, me.we);
                    check("mem_addr", mem_addr_o, me.addr);
                    if (me.chk_data) check("mem_wb_data", mem_data_o, me.data);
                end
            end
            if (!rst_i && sram_enable_o && sram_write_o) begin
                if (sram_q.size() == 0) fail_now("sram_unexpected_write");
                else begin
                    se = sram_q.pop_front();
                    check("sram_idx", sram_addr_o, se.idx);
                    check("sram_tag", sram_tag_o, se.tag);
                    check("sram_data", sram_data_o, se.data);
                end
            end
            if (!rst_i && cpu_req_i && !cpu_stall_o && !cpu_we_i) begin
                if (cpu_q.size() == 0) fail_now("cpu_unexpected_load");
                else begin
                    ce = cpu_q.pop_front();
                    check("cpu_load_data", cpu_data_o, ce);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_stall, input string name);
        int stalls;
        stalls = 0;
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data;
        forever begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            stalls++;
            if (stalls > 200) begin
                fail_now({name, "_stall_timeout"});
                break;
            end
        end
        check({name, "_stall_cycles"}, stalls, exp_stall);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    logic [255:0] l40, l240, l440, l6a0, l880, la00, held_data;
    int n;

    initial begin
        l40  = line_pat(32'h40);
        l240 = line_pat(32'h240);
        l440 = line_pat(32'h440);
        l6a0 = line_pat(32'h6A0);
        l880 = line_pat(32'h880);
        la00 = line_pat(32'hA00);

        rst_i = 1'b1; sram_clr = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_data", mem_data_o, 256'h0);
        check("rst_sram_write", sram_write_o, 1'b0);
        check("rst_state", dut.r_state == IDLE, 1'b1);
        rst_i = 1'b0; sram_clr = 1'b0;
        @(negedge clk_i);

        // Cold load: one refill, word 0 returned, stall = latency + 2
        exp_mem(1'b0, 32'h40, '0);
        exp_sram(4'd2, entry(1, 0, 23'd0), l40);
        cpu_q.push_back(l40[31:0]);
        access(1'b0, 32'h40, '0, MEM_LAT + 2, "cold_load");

        // Store hit, no stall, word 1 replaced and dirty set
        exp_sram(4'd2, entry(1, 1, 23'd0), merge(l40, 32'hDEADBEEF, 1));
        access(1'b1, 32'h44, 32'hDEADBEEF, 0, "store_hit");

        // Load hit on the stored word
        cpu_q.push_back(32'hDEADBEEF);
        access(1'b0, 32'h44, '0, 0, "load_hit");

        // Store miss into the other (invalid) way of set 2: refill then merged install
        exp_mem(1'b0, 32'h240, '0);
        exp_sram(4'd2, entry(1, 1, 23'd1), merge(l240, 32'h12345678, 0));
        exp_sram(4'd2, entry(1, 1, 23'd1), merge(l240, 32'h12345678, 0));
        access(1'b1, 32'h240, 32'h12345678, MEM_LAT + 2, "store_miss_set2");

        // Both ways dirty: third tag evicts LRU way 0 (tag 0) via write-back
        exp_mem(1'b1, 32'h40, merge(l40, 32'hDEADBEEF, 1));
        exp_mem(1'b0, 32'h440, '0);
        exp_sram(4'd2, entry(1, 0, 23'd2), l440);
        cpu_q.push_back(l440[31:0]);
        access(1'b0, 32'h440, '0, 2 * MEM_LAT + 2, "dirty_miss");

        // Store miss to a clean set, word 3; replayed store and a load both hit
        exp_mem(1'b0, 32'h6A0, '0);
        exp_sram(4'd5, entry(1, 1, 23'd3), merge(l6a0, 32'hCAFEF00D, 3));
        exp_sram(4'd5, entry(1, 1, 23'd3), merge(l6a0, 32'hCAFEF00D, 3));
        access(1'b1, 32'h6AC, 32'hCAFEF00D, MEM_LAT + 2, "store_miss_clean");
        cpu_q.push_back(32'hCAFEF00D);
        access(1'b0, 32'h6AC, '0, 0, "load_after_store_miss");

        // Memory stalls 20 cycles: outputs stay constant, CPU stays stalled
        exp_mem(1'b0, 32'h880, '0);
        exp_sram(4'd4, entry(1, 0, 23'd4), l880);
        cpu_q.push_back(l880[3*32 +: 32]);
        mem_mode = 1;
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h88C; cpu_data_i = '0;
        @(negedge clk_i);
        check("hold_miss_stall", cpu_stall_o, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (i == 0) held_data = mem_data_o;
            check("hold_mem_req", mem_req_o, 1'b1);
            check("hold_mem_addr", mem_addr_o, 32'h880);
            check("hold_mem_data", mem_data_o, held_data);
            check("hold_cpu_stall", cpu_stall_o, 1'b1);
        end
        mem_mode = 0;
        n = 0;
        while (cpu_stall_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("hold_release_cycles", n, 5);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);

        // Reset during refill: request drops at once, later acks ignored
        mem_mode = 1;
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hA00;
        repeat (3) @(negedge clk_i);
        check("rst_mid_pre_req", mem_req_o, 1'b1);
        check("rst_mid_pre_addr", mem_addr_o, 32'hA00);
        rst_i = 1'b1;
        #1;
        check("rst_mid_req_clear", mem_req_o, 1'b0);
        check("rst_mid_state", dut.r_state == IDLE, 1'b1);
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        mem_mode = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("stray_ack_req", mem_req_o, 1'b0);
            check("stray_ack_state", dut.r_state == IDLE, 1'b1);
        end
        mem_mode = 0;
        @(negedge clk_i);

        // Discarded refill: the same load misses again from scratch
        exp_mem(1'b0, 32'hA00, '0);
        exp_sram(4'd0, entry(1, 0, 23'd5), la00);
        cpu_q.push_back(la00[31:0]);
        access(1'b0, 32'hA00, '0, MEM_LAT + 2, "post_reset_load");

        repeat (3) @(negedge clk_i);
        check("mem_q_drained", mem_q.size(), 0);
        check("sram_q_drained", sram_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
